latch_bank_sequencer: RTL

Arbitrates several requesters for a shared bank of level-sensitive D latches and sequences each write as setup, enable pulse, then hold. The winner's data is driven onto the bank's data inputs, the enable is held high for a programmed number of cycles, and the data stays stable afterwards so the latch closes cleanly. Sits between the requesting logic and the latch bank, and owns the bank's enable line.

---
 rtl/latch_bank_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer: arbitrated setup/enable/hold write sequencer for a latch bank; LATCH_SEQ_FIXED_PRIO_EN selects fixed priority
module latch_bank_sequencer #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       done,
    output logic                       busy,
    output logic [WIDTH-1:0]           latch_d,
    output logic                       latch_en
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CM = EN_CYCLES > HOLD_CYCLES ? EN_CYCLES : HOLD_CYCLES;
    localparam int CW = $clog2(CM) + 1;
    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [IW-1:0] win, idx;
    logic last;
`ifdef LATCH_SEQ_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'(i);
            win = req[idx] ? idx : win;
        end
    end
`else
    logic [IW-1:0] ptr;
    // search order starts at ptr; descending loop leaves the first hit in win
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            win = req[idx] ? idx : win;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= '0;
        else if (state == HOLD && last)
            ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + IW'(1);
`endif
    assign last = state == ENABLE ? cnt == CW'(EN_CYCLES - 1) : cnt == CW'(HOLD_CYCLES - 1);
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE   ? (|req ? SETUP : IDLE) :
                  state == SETUP  ? ENABLE :
                  state == ENABLE ? (last ? HOLD : ENABLE) :
                                    (last ? IDLE : HOLD);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= '0;
            grant_id <= '0;
            done     <= 1'b0;
            latch_d  <= '0;
            latch_en <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
            latch_en <= state_n == ENABLE;
            done     <= state == HOLD && last;
            if (state == IDLE && |req) begin
                gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                grant_id <= win;
                latch_d  <= req_data[int'(win)*WIDTH +: WIDTH];
            end else if (state == HOLD && last)
                gnt <= '0;
        end
endmodule
